// File: rtl/deser_pkg.sv
// rtl/deser_pkg.sv - shared types and helpers for the serial-to-parallel deserializer
package deser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } deser_state_t;

    // Position within the word for the k-th accepted bit (k is 0-based).
    function automatic int unsigned bit_pos(
        input int unsigned k,
        input int unsigned width,
        input bit          msb_first
    );
        return msb_first ? (width - 1 - k) : k;
    endfunction

endpackage

// File: rtl/deser_word_fifo.sv
// rtl/deser_word_fifo.sv - DEPTH-entry word queue between the assembler and the consumer
module deser_word_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic                         clock_100KHz,
    input  logic                         reset,
    input  logic                         push,
    input  logic [DATA_W-1:0]            push_data,
    input  logic                         pop,
    output logic [DATA_W-1:0]            head,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   fill
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [FW-1:0]     count;
    logic              do_push;
    logic              do_pop;

    // Pointers wrap at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == FW'(DEPTH));
    assign fill    = count;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Consumers see zeros rather than stale storage when nothing is queued.
    assign head    = empty ? '0 : mem[rd_ptr];

    // Word storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clock_100KHz) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop together leave occupancy unchanged.
    always_ff @(posedge clock_100KHz) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + FW'(1);
                2'b01:   count <= count - FW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/deserializer_n.sv
// rtl/deserializer_n.sv - serial-to-parallel converter feeding a word queue
module deserializer_n
    import deser_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 2,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                         clock_100KHz,
    input  logic                         reset,
    input  logic                         data_in,
    input  logic                         write_in,
    input  logic                         abort_in,
    output logic                         status_out,
    output logic                         data_ready,
    output logic [DATA_W-1:0]            data_out,
    input  logic                         ack_in,
    output logic                         overrun_out,
    output logic [$clog2(DEPTH+1)-1:0]   fill_out
);
    localparam int CNTW = $clog2(DATA_W);

    deser_state_t      state;
    deser_state_t      state_next;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_next;
    logic [DATA_W-1:0] word_full;
    logic [CNTW-1:0]   cnt;
    logic [CNTW-1:0]   cnt_next;
    logic [CNTW-1:0]   pos;
    logic              push;
    logic              overrun_set;
    logic              fifo_empty;
    logic              fifo_full;

    // Status comes from registered occupancy only, so a same-cycle pop never unblocks a bit.
    assign status_out = !fifo_full;
    assign data_ready = !fifo_empty;
    assign pos        = CNTW'(bit_pos(32'(cnt), DATA_W, MSB_FIRST));

    // Next-state, shift-register and push decode; abort outranks everything.
    always_comb begin
        state_next      = state;
        shreg_next      = shreg;
        cnt_next        = cnt;
        push            = 1'b0;
        overrun_set     = 1'b0;
        word_full       = shreg;
        word_full[pos]  = data_in;
        if (abort_in) begin
            state_next = IDLE;
            shreg_next = '0;
            cnt_next   = '0;
        end else if (write_in && !status_out) begin
            overrun_set = 1'b1;
        end else if (write_in) begin
            case (state)
                IDLE: begin
                    shreg_next = word_full;
                    cnt_next   = CNTW'(1);
                    state_next = SHIFT;
                end
                SHIFT: begin
                    if (cnt == CNTW'(DATA_W - 1)) begin
                        push       = 1'b1;
                        shreg_next = '0;
                        cnt_next   = '0;
                        state_next = IDLE;
                    end else begin
                        shreg_next = word_full;
                        cnt_next   = cnt + CNTW'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Assembler state register.
    always_ff @(posedge clock_100KHz) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Shift register, bit counter and sticky overrun flag.
    always_ff @(posedge clock_100KHz) begin
        if (reset) begin
            shreg       <= '0;
            cnt         <= '0;
            overrun_out <= 1'b0;
        end else begin
            shreg <= shreg_next;
            cnt   <= cnt_next;
            if (overrun_set) begin
                overrun_out <= 1'b1;
            end
        end
    end

    deser_word_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clock_100KHz (clock_100KHz),
        .reset        (reset),
        .push         (push),
        .push_data    (word_full),
        .pop          (ack_in),
        .head         (data_out),
        .empty        (fifo_empty),
        .full         (fifo_full),
        .fill         (fill_out)
    );

endmodule

// File: tb/tb_deserializer_n.sv
// tb/tb_deserializer_n.sv - directed self-checking bench for deserializer_n
`timescale 1ns/1ps
module tb_deserializer_n;

    logic       clock_100KHz = 1'b0;
    logic       reset        = 1'b1;
    logic       data_in      = 1'b0;
    logic       write_in     = 1'b0;
    logic       abort_in     = 1'b0;
    logic       ack_in       = 1'b0;

    logic       l_status, l_ready, l_overrun;
    logic [7:0] l_data;
    logic [1:0] l_fill;
    logic       m_status, m_ready, m_overrun;
    logic [7:0] m_data;
    logic [1:0] m_fill;

    int tests  = 0;
    int failed = 0;

    always #5 clock_100KHz = ~clock_100KHz;

    deserializer_n #(.DATA_W(8), .DEPTH(2), .MSB_FIRST(1'b0)) dut_lsb (
        .clock_100KHz (clock_100KHz),
        .reset        (reset),
        .data_in      (data_in),
        .write_in     (write_in),
        .abort_in     (abort_in),
        .status_out   (l_status),
        .data_ready   (l_ready),
        .data_out     (l_data),
        .ack_in       (ack_in),
        .overrun_out  (l_overrun),
        .fill_out     (l_fill)
    );

    deserializer_n #(.DATA_W(8), .DEPTH(2), .MSB_FIRST(1'b1)) dut_msb (
        .clock_100KHz (clock_100KHz),
        .reset        (reset),
        .data_in      (data_in),
        .write_in     (write_in),
        .abort_in     (abort_in),
        .status_out   (m_status),
        .data_ready   (m_ready),
        .data_out     (m_data),
        .ack_in       (ack_in),
        .overrun_out  (m_overrun),
        .fill_out     (m_fill)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle 1ns past it before anything is sampled.
    task automatic step();
        @(posedge clock_100KHz);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            data_in  = w[i];
            write_in = 1'b1;
            step();
        end
        write_in = 1'b0;
        data_in  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic do_ack();
        ack_in = 1'b1;
        step();
        ack_in = 1'b0;
    endtask

    initial begin
        #1;
        step();
        step();
        reset = 1'b0;

        check("rst_status",  32'(l_status),  32'd1);
        check("rst_ready",   32'(l_ready),   32'd0);
        check("rst_data",    32'(l_data),    32'h0);
        check("rst_overrun", 32'(l_overrun), 32'd0);
        check("rst_fill",    32'(l_fill),    32'd0);

        // Bits 1,0,1,1,0,0,0,0: LSB-first gives 0x0D, MSB-first gives 0xB0.
        send_bits(8'h0D, 7);
        check("lsb_not_ready_7bits", 32'(l_ready), 32'd0);
        send_bits(8'h00, 1);
        check("lsb_ready", 32'(l_ready), 32'd1);
        check("lsb_data",  32'(l_data),  32'h0D);
        check("lsb_fill",  32'(l_fill),  32'd1);
        check("msb_ready", 32'(m_ready), 32'd1);
        check("msb_data",  32'(m_data),  32'hB0);
        do_ack();
        check("lsb_ack_empty", 32'(l_ready), 32'd0);
        check("lsb_ack_zero",  32'(l_data),  32'h0);

        // Fill the two-entry queue, then offer a third word that must be dropped.
        do_reset();
        send_bits(8'hA5, 8);
        check("fill1_fill",   32'(l_fill),   32'd1);
        check("fill1_status", 32'(l_status), 32'd1);
        send_bits(8'h3C, 8);
        check("fill2_fill",    32'(l_fill),    32'd2);
        check("fill2_status",  32'(l_status),  32'd0);
        check("fill2_overrun", 32'(l_overrun), 32'd0);
        send_bits(8'hFF, 8);
        check("ovr_flag", 32'(l_overrun), 32'd1);
        check("ovr_fill", 32'(l_fill),    32'd2);
        check("ovr_head", 32'(l_data),    32'hA5);
        do_ack();
        check("ack1_data",   32'(l_data),   32'h3C);
        check("ack1_fill",   32'(l_fill),   32'd1);
        check("ack1_status", 32'(l_status), 32'd1);
        do_ack();
        check("ack2_ready",   32'(l_ready),   32'd0);
        check("ack2_data",    32'(l_data),    32'h0);
        check("ovr_sticky",   32'(l_overrun), 32'd1);
        send_bits(8'h11, 8);
        check("post_ovr_word", 32'(l_data), 32'h11);
        do_ack();

        // Final bit of 0x22 and an ack land on the same edge.
        do_reset();
        send_bits(8'h11, 8);
        check("pp_pre_fill", 32'(l_fill), 32'd1);
        send_bits(8'h22, 7);
        data_in  = 1'b0;
        write_in = 1'b1;
        ack_in   = 1'b1;
        step();
        write_in = 1'b0;
        ack_in   = 1'b0;
        check("pp_fill",  32'(l_fill),  32'd1);
        check("pp_ready", 32'(l_ready), 32'd1);
        check("pp_data",  32'(l_data),  32'h22);

        // Abort after three bits, with a write on the abort cycle.
        do_reset();
        send_bits(8'h07, 3);
        data_in  = 1'b1;
        write_in = 1'b1;
        abort_in = 1'b1;
        step();
        write_in = 1'b0;
        abort_in = 1'b0;
        check("abort_ready",   32'(l_ready),   32'd0);
        send_bits(8'h5A, 8);
        check("abort_data",    32'(l_data),    32'h5A);
        check("abort_fill",    32'(l_fill),    32'd1);
        check("abort_overrun", 32'(l_overrun), 32'd0);
        do_ack();
        check("abort_drained", 32'(l_ready), 32'd0);

        // Reset in the middle of a word, with a word already queued.
        do_reset();
        send_bits(8'h33, 8);
        send_bits(8'h1F, 5);
        do_reset();
        check("mrst_status",  32'(l_status),  32'd1);
        check("mrst_ready",   32'(l_ready),   32'd0);
        check("mrst_data",    32'(l_data),    32'h0);
        check("mrst_overrun", 32'(l_overrun), 32'd0);
        check("mrst_fill",    32'(l_fill),    32'd0);
        send_bits(8'h81, 8);
        check("mrst_word", 32'(l_data), 32'h81);
        check("mrst_wfill", 32'(l_fill), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
